// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard port bridge: default port numbers and
// status register field positions.
package kbd_pkg;

    localparam logic [7:0] DEF_PORT_DATA = 8'h00;
    localparam logic [7:0] DEF_PORT_STAT = 8'h01;

    localparam int ST_NE   = 0;
    localparam int ST_FULL = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_IEN  = 3;

    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 4;

endpackage

// File: rtl/kbd_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop
// frees the head slot on the same edge.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [3:0]   count,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 4'(DEPTH));
    assign empty   = (count == 4'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_port.sv
// Keyboard byte FIFO exposed on two CPU I/O ports with a level interrupt.
// Define KBD_PORT_IRQ_EN to build the ien register and irq output.
module kbd_port
    import kbd_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] PORT_DATA = DEF_PORT_DATA,
    parameter logic [7:0] PORT_STAT = DEF_PORT_STAT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       kdone,
    input  logic [7:0] ascii,
    input  logic [7:0] port_a,
    input  logic       port_rd,
    input  logic       port_we,
    input  logic [7:0] port_o,
    output logic [7:0] port_q,
    output logic       sel,
    output logic       irq
);
    logic       hit_data;
    logic       hit_stat;
    logic       pop_ok;
    logic       ovf_set;
    logic       stat_wr;
    logic       ovf;
    logic       ien;
    logic [7:0] head;
    logic [7:0] status;
    logic [3:0] count;
    logic       full;
    logic       empty;

    assign hit_data = (port_a == PORT_DATA);
    assign hit_stat = (port_a == PORT_STAT);
    assign sel      = hit_data || hit_stat;
    assign pop_ok   = port_rd && hit_data && !empty;
    assign stat_wr  = port_we && hit_stat;
    // A full FIFO only drops the byte when no pop frees a slot this edge.
    assign ovf_set  = kdone && full && !pop_ok;

    kbd_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (kdone),
        .pop     (pop_ok),
        .din     (ascii),
        .dout    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (stat_wr && port_o[ST_OVF]) begin
            ovf <= 1'b0;
        end
    end

`ifdef KBD_PORT_IRQ_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ien <= 1'b0;
        end else if (stat_wr) begin
            ien <= port_o[ST_IEN];
        end
    end
    assign irq = ien && !empty;
    logic unused_port_o;
    assign unused_port_o = ^{port_o[7:4], port_o[1:0]};
`else
    assign ien = 1'b0;
    assign irq = 1'b0;
    logic unused_port_o;
    assign unused_port_o = ^{port_o[7:3], port_o[1:0]};
`endif

    always_comb begin
        status                           = 8'h00;
        status[ST_NE]                    = !empty;
        status[ST_FULL]                  = full;
        status[ST_OVF]                   = ovf;
        status[ST_IEN]                   = ien;
        status[ST_CNT_LSB +: ST_CNT_W]   = count;
    end

    always_comb begin
        port_q = 8'hFF;
        if (hit_data) begin
            port_q = empty ? 8'h00 : head;
        end else if (hit_stat) begin
            port_q = status;
        end
    end

endmodule

// File: tb/tb_kbd_port.sv
// Scoreboard bench for kbd_port: stimulus queues expected port reads,
// a negedge monitor pops and compares them against the DUT.
module tb_kbd_port;

`ifdef KBD_PORT_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif
    localparam logic [7:0] PD = 8'h00;
    localparam logic [7:0] PS = 8'h01;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       kdone = 1'b0;
    logic [7:0] ascii = 8'h00;
    logic [7:0] port_a = 8'h20;
    logic       port_rd = 1'b0;
    logic       port_we = 1'b0;
    logic [7:0] port_o = 8'h00;
    logic [7:0] port_q;
    logic       sel;
    logic       irq;

    kbd_port dut (
        .clock   (clock),
        .reset_n (reset_n),
        .kdone   (kdone),
        .ascii   (ascii),
        .port_a  (port_a),
        .port_rd (port_rd),
        .port_we (port_we),
        .port_o  (port_o),
        .port_q  (port_q),
        .sel     (sel),
        .irq     (irq)
    );

    always #20 clock = ~clock;

    typedef struct {
        string      nm;
        logic [7:0] q;
        logic       sel;
        logic       irq;
    } exp_t;

    exp_t sb[$];
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge clock) begin
        if (chk_en) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: got q=%02h, required a queued entry", port_q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (port_q !== e.q || sel !== e.sel || irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s: got q=%02h sel=%0b irq=%0b, required q=%02h sel=%0b irq=%0b",
                             e.nm, port_q, sel, irq, e.q, e.sel, e.irq);
                end
            end
        end
    end

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cyc(input logic kd, input logic [7:0] asc, input logic rd,
                       input logic we, input logic [7:0] a, input logic [7:0] wd,
                       input logic chk, input logic [7:0] eq, input logic esel,
                       input logic ei, input string nm);
        exp_t e;
        kdone   = kd;
        ascii   = asc;
        port_rd = rd;
        port_we = we;
        port_a  = a;
        port_o  = wd;
        chk_en  = chk;
        if (chk) begin
            e.nm = nm; e.q = eq; e.sel = esel; e.irq = ei;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        kdone = 1'b0; port_rd = 1'b0; port_we = 1'b0; chk_en = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        cyc(1, v, 0, 0, 8'h20, 0, 0, 0, 0, 0, "");
    endtask
    task automatic wr_stat(input logic [7:0] v);
        cyc(0, 0, 0, 1, PS, v, 0, 0, 0, 0, "");
    endtask
    task automatic chk_stat(input logic [7:0] v, input logic ei, input string nm);
        cyc(0, 0, 0, 0, PS, 0, 1, v, 1, ei, nm);
    endtask
    task automatic rd_data(input logic [7:0] v, input logic ei, input string nm);
        cyc(0, 0, 1, 0, PD, 0, 1, v, 1, ei, nm);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #50;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Reset state and idle decode
        chk_stat(8'h00, 0, "reset_stat");
        rd_data(8'h00, 0, "empty_data_read");
        chk_stat(8'h00, 0, "stat_after_empty_read");
        cyc(0, 0, 0, 0, 8'h20, 0, 1, 8'hFF, 0, 0, "unselected_port");

        // Three bytes in order
        push(8'h41); push(8'h42); push(8'h43);
        chk_stat(8'h31, 0, "stat_three");
        rd_data(8'h41, 0, "read_41");
        rd_data(8'h42, 0, "read_42");
        rd_data(8'h43, 0, "read_43");
        chk_stat(8'h00, 0, "stat_drained");

        // Overflow: ninth byte lost, ovf sticky until cleared
        for (int i = 1; i <= 9; i++) push(8'(i));
        chk_stat(8'h87, 0, "stat_overflow");
        wr_stat(8'h04);
        chk_stat(8'h83, 0, "stat_ovf_cleared");
        for (int i = 1; i <= 8; i++) rd_data(8'(i), 0, "read_ovf_seq");
        chk_stat(8'h00, 0, "stat_after_ovf_drain");

        // Full FIFO, push and pop on the same edge
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        chk_stat(8'h83, 0, "stat_full");
        cyc(1, 8'h55, 1, 0, PD, 0, 1, 8'h11, 1, 0, "full_push_pop_head");
        chk_stat(8'h83, 0, "stat_full_after_pushpop");
        for (int i = 1; i < 8; i++) rd_data(8'h11 + 8'(i), 0, "read_full_seq");
        rd_data(8'h55, 0, "read_55_last");
        chk_stat(8'h00, 0, "stat_after_full_drain");

        // Interrupt enable and clear
        wr_stat(8'h08);
        push(8'h0D);
        chk_stat(IRQ ? 8'h19 : 8'h11, IRQ, "irq_after_push");
        rd_data(8'h0D, IRQ, "read_0D");
        chk_stat(IRQ ? 8'h08 : 8'h00, 0, "irq_after_pop");
        push(8'h0E);
        chk_stat(IRQ ? 8'h19 : 8'h11, IRQ, "irq_second_push");
        wr_stat(8'h00);
        chk_stat(8'h11, 0, "irq_after_ien_clear");
        rd_data(8'h0E, 0, "read_0E");

        // Asynchronous reset mid-cycle with buffered bytes
        wr_stat(8'h08);
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        chk_stat(IRQ ? 8'h49 : 8'h41, IRQ, "stat_four");
        port_a = PS;
        #5;
        reset_n = 1'b0;
        #1;
        if (port_q !== 8'h00 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got q=%02h irq=%0b, required q=00 irq=0", port_q, irq);
        end
        n_tests++;
        @(posedge clock);
        #1;
        cyc(0, 0, 0, 0, PS, 0, 1, 8'h00, 1, 0, "stat_in_reset");
        reset_n = 1'b1;
        rd_data(8'h00, 0, "data_after_reset");
        chk_stat(8'h00, 0, "stat_after_reset");

        @(posedge clock);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_port.md
# kbd_port

Keyboard port bridge between the PS/2 `keyboard` decoder and the LCR580 I/O port bus. Buffers decoded ASCII bytes (one per `kdone` pulse) in a small FIFO, exposes them on a data port and a status/control port, and raises a level interrupt request while bytes are pending. Sits downstream of `keyboard` and upstream of the CPU's `port_in` mux in the board top level.

## Interface
- `DEPTH`, 8: FIFO entries; legal values 2, 4, 8.
- `PORT_DATA`, 8'h00: port number of the data register (read pops).
- `PORT_STAT`, 8'h01: port number of the status/control register.

- `clock`  in  1  system clock (25 MHz domain, same as CPU).
- `reset_n`  in  1  reset; **one clock; reset is asynchronous and active-low**.
- `kdone`  in  1  one-cycle pulse from `keyboard`: `ascii` is valid.
- `ascii`  in  8  decoded key code.
- `port_a`  in  8  CPU port number.
- `port_rd`  in  1  one-cycle CPU port read strobe.
- `port_we`  in  1  one-cycle CPU port write strobe.
- `port_o`  in  8  CPU write data.
- `port_q`  out  8  read data for the selected port.
- `sel`  out  1  high when `port_a` is `PORT_DATA` or `PORT_STAT`; top level uses it to mux `port_q` into `port_in`.
- `irq`  out  1  interrupt request, level.

## Operation
- FIFO: `DEPTH` x 8 storage, read/write pointers of log2(`DEPTH`) bits with natural wrap, count 0..`DEPTH` (4 bits).
- Push: `kdone`=1 and not full -> store `ascii` at write pointer, advance it, count+1.
- Overflow: `kdone`=1 while full with no pop in the same cycle -> byte dropped, sticky `ovf` set.
- Pop: `port_rd`=1 and `port_a`==`PORT_DATA` and not empty -> advance read pointer, count-1.
- Empty data read: `port_q`=8'h00, no pointer or count change.
- Simultaneous push and pop: both performed and count unchanged. When full, the push is accepted because the slot is freed the same edge. When empty, only the push occurs.
- Status byte (read `PORT_STAT`):
  - bit0 = not empty
  - bit1 = full
  - bit2 = `ovf`
  - bit3 = `ien`
  - bits7:4 = count
  - Reading has no side effects.
- Control (write `PORT_STAT`):
  - bit3 -> `ien`
  - bit2=1 clears `ovf`; bit2=0 leaves `ovf` unchanged.
  - If overflow set and clear occur on the same edge, set wins.
- Writes to `PORT_DATA` are ignored.
- `port_q` when neither port is selected: 8'hFF.
- `irq` = `ien` & not empty.

## Timing
- Reset values: pointers 0, count 0, `ovf` 0, `ien` 0, `irq` 0. `port_q` follows the combinational decode: status 8'h00, data 8'h00, otherwise 8'hFF.
- Reset asserted mid-operation discards all buffered bytes immediately (asynchronous).
- `port_q`, `sel`: combinational from `port_a` and current registered state. Data valid in the same cycle as `port_rd`; the pop takes effect at the closing edge.
- Push latency: a byte pushed at edge N is readable at `PORT_DATA` from cycle N+1. The status not-empty bit and `irq` rise after edge N.
- `irq` falls the cycle after the pop that empties the FIFO, or after `ien` is cleared.
- No throughput limit: one push and one pop per cycle.

## Configuration
- `KBD_PORT_IRQ_EN` defined: `ien` register and `irq` logic present as described.
- `KBD_PORT_IRQ_EN` undefined:
  - `irq` tied 0.
  - Status bit3 reads 0.
  - Writes to bit3 are ignored.
  - Software polls status bit0.

## Structure
- Shared package `kbd_pkg`:
  - default port numbers
  - status bit positions (`ST_NE`, `ST_FULL`, `ST_OVF`, `ST_IEN`)
  - count field position
- Sub-module `kbd_fifo`: generic synchronous FIFO with storage, pointers, count, full/empty and simultaneous push/pop rule.
- `kbd_port` holds port decode, `ovf`/`ien` registers, read mux and `irq`.

## Test plan
- Reset, then read `PORT_STAT`: 8'h00. Read `PORT_DATA`: 8'h00 with count still 0. Read port 8'h20: 8'hFF, `sel`=0.
- Push 8'h41, 8'h42, 8'h43 -> status 8'h31. Three data reads return 41, 42, 43 in order -> status 8'h00.
- Push 9 bytes 8'h01..8'h09 with `DEPTH`=8 -> status 8'h87, 8'h09 lost. Write 8'h04 to `PORT_STAT` -> status 8'h83. Reads return 01..08.
- FIFO full: `kdone` with 8'h55 in the same cycle as a data read -> read returns head, count stays 8, `ovf` stays 0, and 8'h55 is read last.
- Write 8'h08 to `PORT_STAT`, push 8'h0D -> `irq`=1 the next cycle. Data read -> `irq`=0 the next cycle. With the macro undefined, `irq` stays 0 and status is 8'h11 after the push.
- Push 4 bytes, assert `reset_n`=0 mid-cycle -> status 8'h00 immediately, and the next data read returns 8'h00.
